riscuin_mc_sequencer: RTL

Multi-cycle control sequencer for the next-generation RISCuin core. It replaces the single-cycle enable logic with an explicit FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine. It tolerates program-memory and data-bus wait states, enforces a bus timeout, detects misaligned or illegal data accesses, and counts retired instructions. It sits between the instruction decoder, the program-count control unit, the register bank and the data bus controller.

---
 rtl/riscuin_mc_sequencer_if.sv | 50 +++++
 rtl/riscuin_mc_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/riscuin_mc_sequencer_if.sv
// -----------------------------------------------------------------------------
// riscuin_mc_sequencer_if
// Bundle of the control/handshake signals around the multi-cycle sequencer.
//   Decoder/ALU side : instr_valid, data_r, data_w, data_size, addr_lo, reg_w_dec
//   Data bus side    : bus_ready, bus_busy -> bus_req_r, bus_req_w
//   PC / reg bank    : rb_ready, pc_at_end, halt_req -> instr_latch, pc_enable,
//                      reg_w_en
//   Status           : halted, trap, trap_cause, state, retired
// master = environment driving the sequencer, slave = the sequencer itself.
// -----------------------------------------------------------------------------
interface riscuin_mc_sequencer_if #(
    parameter int RET_WIDTH = 32
);
    logic                 rb_ready;
    logic                 instr_valid;
    logic                 data_r;
    logic                 data_w;
    logic [1:0]           data_size;
    logic [1:0]           addr_lo;
    logic                 reg_w_dec;
    logic                 bus_ready;
    logic                 bus_busy;
    logic                 pc_at_end;
    logic                 halt_req;

    logic                 instr_latch;
    logic                 pc_enable;
    logic                 reg_w_en;
    logic                 bus_req_r;
    logic                 bus_req_w;
    logic                 halted;
    logic                 trap;
    logic [1:0]           trap_cause;
    logic [2:0]           state;
    logic [RET_WIDTH-1:0] retired;

    modport master (
        output rb_ready, instr_valid, data_r, data_w, data_size, addr_lo,
               reg_w_dec, bus_ready, bus_busy, pc_at_end, halt_req,
        input  instr_latch, pc_enable, reg_w_en, bus_req_r, bus_req_w,
               halted, trap, trap_cause, state, retired
    );

    modport slave (
        input  rb_ready, instr_valid, data_r, data_w, data_size, addr_lo,
               reg_w_dec, bus_ready, bus_busy, pc_at_end, halt_req,
        output instr_latch, pc_enable, reg_w_en, bus_req_r, bus_req_w,
               halted, trap, trap_cause, state, retired
    );
endinterface

// File: rtl/riscuin_mc_sequencer.sv
// -----------------------------------------------------------------------------
// riscuin_mc_sequencer
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK controller for the RISCuin
// core. Tolerates program-memory and data-bus wait states, traps on illegal or
// misaligned data accesses and on a bus timeout, and counts retired
// instructions.
// Ports:
//   clk  - core clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - riscuin_mc_sequencer_if.slave (all control/handshake/status signals)
//
//   state      | code | meaning
//   -----------+------+----------------------------------------------------
//   RESET_WAIT |  0   | waiting for the register bank to come up
//   FETCH      |  1   | waiting for instr_valid, latch instruction
//   DECODE     |  2   | one-cycle decode slot
//   EXECUTE    |  3   | access legality check, choose MEM or WRITEBACK
//   MEM        |  4   | data bus access with wait states and timeout
//   WRITEBACK  |  5   | commit rd, advance PC, count retirement
//   HALT       |  6   | parked until halt_req and pc_at_end both drop
//   TRAP       |  7   | fault latched, exit only through reset
// -----------------------------------------------------------------------------
module riscuin_mc_sequencer #(
    parameter int BUS_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 5,
    parameter int RET_WIDTH   = 32
) (
    input logic                  clk,
    input logic                  rst,
    riscuin_mc_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        RESET_WAIT = 3'd0,
        FETCH      = 3'd1,
        DECODE     = 3'd2,
        EXECUTE    = 3'd3,
        MEM        = 3'd4,
        WRITEBACK  = 3'd5,
        HALT       = 3'd6,
        TRAP       = 3'd7
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    state_t               state_q;
    state_t               state_nxt;
    logic [1:0]           cause_nxt;
    logic [1:0]           cause_q;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic [RET_WIDTH-1:0] retired_q;
    logic                 req_r_q;
    logic                 req_w_q;

    logic access;
    logic illegal;
    logic misaligned;
    logic bus_done;

    assign access     = bus.data_r | bus.data_w;
    assign illegal    = (bus.data_r & bus.data_w) | (access & (bus.data_size == 2'b11));
    assign misaligned = access & (((bus.data_size == 2'b01) & bus.addr_lo[0]) |
                                  ((bus.data_size == 2'b10) & (bus.addr_lo != 2'b00)));
    assign bus_done   = bus.bus_ready & ~bus.bus_busy;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RESET_WAIT;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        cause_nxt = 2'b00;
        case (state_q)
            RESET_WAIT: if (bus.rb_ready) state_nxt = FETCH;
            FETCH:      if (bus.instr_valid) state_nxt = DECODE;
            DECODE:     state_nxt = EXECUTE;
            EXECUTE: begin
                if (illegal) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else if (misaligned) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_MISALIGN;
                end else if (access) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WRITEBACK;
                end
            end
            MEM: begin
                // completion in the terminal-count cycle takes priority
                if (bus_done) begin
                    state_nxt = WRITEBACK;
                end else if (wait_cnt == '0) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            WRITEBACK:  state_nxt = (bus.halt_req | bus.pc_at_end) ? HALT : FETCH;
            HALT:       if (!bus.halt_req && !bus.pc_at_end) state_nxt = FETCH;
            TRAP:       state_nxt = TRAP;
            default:    state_nxt = RESET_WAIT;
        endcase
    end

    // Bus requests, wait timer, trap cause and retirement counter.
    // The wait timer is a down-counter loaded with BUS_TIMEOUT-1 on MEM entry;
    // reaching zero without completion is the timeout cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_r_q   <= 1'b0;
            req_w_q   <= 1'b0;
            wait_cnt  <= '0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            if (state_q == EXECUTE && state_nxt == MEM) begin
                req_r_q  <= bus.data_r;
                req_w_q  <= bus.data_w;
                wait_cnt <= CNT_WIDTH'(BUS_TIMEOUT - 1);
            end else begin
                if (state_nxt != MEM) begin
                    req_r_q <= 1'b0;
                    req_w_q <= 1'b0;
                end
                if (state_q == MEM && wait_cnt != '0) begin
                    wait_cnt <= wait_cnt - CNT_WIDTH'(1);
                end
            end
            if (state_q != TRAP && state_nxt == TRAP) begin
                cause_q <= cause_nxt;
            end
            if (state_q == WRITEBACK) begin
                retired_q <= retired_q + RET_WIDTH'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        bus.instr_latch = 1'b0;
        bus.pc_enable   = 1'b0;
        bus.reg_w_en    = 1'b0;
        case (state_q)
            FETCH: bus.instr_latch = bus.instr_valid;
            WRITEBACK: begin
                bus.pc_enable = 1'b1;
                bus.reg_w_en  = bus.reg_w_dec & ~bus.data_w;
            end
            default: ;
        endcase
    end

    assign bus.bus_req_r  = req_r_q;
    assign bus.bus_req_w  = req_w_q;
    assign bus.halted     = (state_q == HALT);
    assign bus.trap       = (state_q == TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;

endmodule
